// File: rtl/enc_mpp_com.sv
// rtl/enc_mpp_com.sv - midpoint-predictor quantizer for 8x2 sample blocks
//
// A block moves through four stages: IDLE (accept), MPC (derive the midpoint
// predictor), QNT (quantize and reconstruct all 16 samples), OUT (present the
// result until the consumer takes it). The mean of the reconstructed top-left
// 2x2 corner carries over to bias the predictor of the next block in the slice.
module enc_mpp_com #(
   parameter int BIT_DEPTH = 8,
   parameter int STEP_SIZE = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [15:0]  blkcounter,
   input  logic [127:0] src,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [127:0] q,
   output logic [127:0] rec,
   output logic [7:0]   mp,
   output logic [15:0]  out_blkcounter
);

   localparam int MIDDLE   = 1 << (BIT_DEPTH - 1);
   localparam int CUR_BIAS = (STEP_SIZE == 0) ? 0 : (1 << (STEP_SIZE - 1));
   localparam int MAX_VAL  = (1 << BIT_DEPTH) - 1;
   localparam int MAX_CLIP = (MIDDLE + 2 * CUR_BIAS > MAX_VAL) ? MAX_VAL : (MIDDLE + 2 * CUR_BIAS);

   localparam logic [10:0] MIDDLE_W   = 11'(MIDDLE);
   localparam logic [10:0] MAX_CLIP_W = 11'(MAX_CLIP);
   localparam logic [10:0] BIAS2_W    = 11'(2 * CUR_BIAS);
   localparam logic [9:0]  BIAS_W     = 10'(CUR_BIAS);
   localparam logic [7:0]  MIDDLE_8   = 8'(MIDDLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MPC  = 2'd1,
      QNT  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           alive_q;
   logic [127:0]   src_q;
   logic [15:0]    blk_q;
   logic [7:0]     mean_q;
   logic [7:0]     mp_q;
   logic [127:0]   q_q;
   logic [127:0]   rec_q;
   logic [15:0]    oblk_q;

   logic           hs;
   logic [7:0]     mean_sel;
   logic [10:0]    mp_t;
   logic [10:0]    mp_c;
   logic [7:0]     mp_d;
   logic [127:0]   q_d;
   logic [127:0]   rec_d;
   logic [9:0]     corner_sum;
   logic [7:0]     mean_d;

   // Quantize one sample against the predictor; returns {rec, q}.
   // The reconstruction is computed wide and signed so it saturates instead of wrapping.
   function automatic logic [15:0] quant(input logic [7:0] s, input logic [7:0] m);
      logic signed [9:0]  r;
      logic [9:0]         a;
      logic [9:0]         mag;
      logic [7:0]         qv;
      logic signed [11:0] rw;
      logic [7:0]         rv;
      r   = $signed({2'b00, s}) - $signed({2'b00, m});
      a   = r[9] ? $unsigned(-r) : $unsigned(r);
      mag = (a + BIAS_W) >> STEP_SIZE;
      qv  = r[9] ? 8'(-mag) : 8'(mag);
      rw  = $signed({4'b0000, m}) + ($signed({{4{qv[7]}}, qv}) <<< STEP_SIZE);
      if (rw < 12'sd0) begin
         rv = 8'd0;
      end else if (rw > 12'sd255) begin
         rv = 8'd255;
      end else begin
         rv = 8'(rw);
      end
      return {rv, qv};
   endfunction

   assign in_rdy         = alive_q & (state_q == IDLE);
   assign hs             = in_vld & in_rdy;
   assign out_vld        = (state_q == OUT);
   assign q              = q_q;
   assign rec            = rec_q;
   assign mp             = mp_q;
   assign out_blkcounter = oblk_q;

   // Next-state logic: fixed three-edge pipeline, then wait for the consumer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hs) state_d = MPC;
         MPC:     state_d = QNT;
         QNT:     state_d = OUT;
         OUT:     if (out_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Predictor: first block of a slice ignores the carried mean.
   always_comb begin
      mean_sel = (blk_q == 16'd0) ? MIDDLE_8 : mean_q;
      mp_t     = {3'b000, mean_sel} + BIAS2_W;
      if (mp_t < MIDDLE_W) begin
         mp_c = MIDDLE_W;
      end else if (mp_t > MAX_CLIP_W) begin
         mp_c = MAX_CLIP_W;
      end else begin
         mp_c = mp_t;
      end
      mp_d = 8'(mp_c);
   end

   // Per-sample quantization plus the corner mean fed to the next block.
   always_comb begin
      q_d   = '0;
      rec_d = '0;
      for (int i = 0; i < 16; i++) begin
         {rec_d[8*i +: 8], q_d[8*i +: 8]} = quant(src_q[8*i +: 8], mp_q);
      end
      corner_sum = {2'b00, rec_d[7:0]} + {2'b00, rec_d[15:8]}
                 + {2'b00, rec_d[71:64]} + {2'b00, rec_d[79:72]};
      mean_d     = 8'(corner_sum >> 2);
   end

   // State register; alive_q keeps in_rdy low until the first edge after reset.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q <= IDLE;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end

   // Capture the source block on the input handshake.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         src_q <= '0;
         blk_q <= '0;
      end else if (hs) begin
         src_q <= src;
         blk_q <= blkcounter;
      end
   end

   // Register the predictor on the MPC->QNT edge.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         mp_q <= '0;
      end else if (state_q == MPC) begin
         mp_q <= mp_d;
      end
   end

   // Register results and update the carried mean on the QNT->OUT edge.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         q_q    <= '0;
         rec_q  <= '0;
         oblk_q <= '0;
         mean_q <= MIDDLE_8;
      end else if (state_q == QNT) begin
         q_q    <= q_d;
         rec_q  <= rec_d;
         oblk_q <= blk_q;
         mean_q <= mean_d;
      end
   end

endmodule

// File: tb/tb_enc_mpp_com.sv
// tb/tb_enc_mpp_com.sv - directed self-checking bench for enc_mpp_com
module tb_enc_mpp_com;

   logic         clk;
   logic         rstn;
   logic         in_vld;
   logic         in_rdy;
   logic [15:0]  blkcounter;
   logic [127:0] src;
   logic         out_vld;
   logic         out_rdy;
   logic [127:0] q;
   logic [127:0] rec;
   logic [7:0]   mp;
   logic [15:0]  out_blkcounter;

   int n_chk;
   int n_fail;

   enc_mpp_com #(.BIT_DEPTH(8), .STEP_SIZE(2)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .in_vld         (in_vld),
      .in_rdy         (in_rdy),
      .blkcounter     (blkcounter),
      .src            (src),
      .out_vld        (out_vld),
      .out_rdy        (out_rdy),
      .q              (q),
      .rec            (rec),
      .mp             (mp),
      .out_blkcounter (out_blkcounter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] rep(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a block and check the fixed pipeline latency to out_vld.
   task automatic send(input logic [15:0] b, input logic [127:0] s);
      blkcounter = b;
      src        = s;
      in_vld     = 1'b1;
      chk("rdy_before_accept", 128'(in_rdy), 128'(1));
      tick();
      in_vld = 1'b0;
      chk("rdy_after_accept", 128'(in_rdy), 128'(0));
      chk("vld_in_mpc", 128'(out_vld), 128'(0));
      tick();
      chk("vld_in_qnt", 128'(out_vld), 128'(0));
      tick();
      chk("vld_in_out", 128'(out_vld), 128'(1));
   endtask

   task automatic chk_out(input string tag, input logic [127:0] eq, input logic [127:0] er,
                          input logic [7:0] em, input logic [15:0] eb);
      chk({tag, "_q"},   q,                     eq);
      chk({tag, "_rec"}, rec,                   er);
      chk({tag, "_mp"},  128'(mp),              128'(em));
      chk({tag, "_blk"}, 128'(out_blkcounter),  128'(eb));
   endtask

   task automatic consume();
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      chk("vld_after_consume", 128'(out_vld), 128'(0));
      chk("rdy_after_consume", 128'(in_rdy), 128'(1));
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rstn       = 1'b1;
      in_vld     = 1'b0;
      out_rdy    = 1'b0;
      blkcounter = '0;
      src        = '0;

      tick();
      tick();
      chk("rst_in_rdy",  128'(in_rdy),         128'(0));
      chk("rst_out_vld", 128'(out_vld),        128'(0));
      chk("rst_q",       q,                    128'(0));
      chk("rst_rec",     rec,                  128'(0));
      chk("rst_mp",      128'(mp),             128'(0));
      chk("rst_blk",     128'(out_blkcounter), 128'(0));
      rstn = 1'b0;
      #1;
      chk("rdy_before_first_edge", 128'(in_rdy), 128'(0));
      tick();
      chk("rdy_first_edge", 128'(in_rdy), 128'(1));

      // first block of slice, flat mid-grey
      send(16'd0, rep(8'd128));
      chk_out("b0", rep(8'hFF), rep(8'd128), 8'd132, 16'd0);

      // consumer stalls while a new source block is offered
      in_vld     = 1'b1;
      blkcounter = 16'd9;
      src        = rep(8'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_vld", 128'(out_vld), 128'(1));
         chk("stall_rdy", 128'(in_rdy),  128'(0));
         chk_out("stall", rep(8'hFF), rep(8'd128), 8'd132, 16'd0);
      end
      in_vld = 1'b0;
      consume();

      // mean 128, saturating reconstruction at the top
      send(16'd1, rep(8'd255));
      chk_out("b1", rep(8'h1F), rep(8'd255), 8'd132, 16'd1);
      consume();

      // mean 255 -> predictor clipped to 132, reconstruction clipped at 0
      send(16'd2, rep(8'd0));
      chk_out("b2", rep(8'hDF), rep(8'd0), 8'd132, 16'd2);
      consume();

      // mean 0 -> predictor clipped up to 128
      send(16'd4, rep(8'd0));
      chk_out("b4", rep(8'hE0), rep(8'd0), 8'd128, 16'd4);
      consume();

      // blkcounter 0 overrides stored mean 0
      send(16'd0, rep(8'd128));
      chk_out("b0_override", rep(8'hFF), rep(8'd128), 8'd132, 16'd0);
      consume();

      // ramp of samples 0,16,...,240; corner mean becomes 72
      send(16'd7, 128'hF0E0D0C0B0A090807060504030201000);
      chk_out("ramp", 128'h1B17130F0B0703FFFBF7F3EFEBE7E3DF,
              128'hF0E0D0C0B0A090807060504030201000, 8'd132, 16'd7);
      consume();

      // reset while the next block sits in QNT
      blkcounter = 16'd1;
      src        = rep(8'd200);
      in_vld     = 1'b1;
      tick();
      in_vld = 1'b0;
      tick();
      rstn = 1'b1;
      #1;
      chk("abort_vld", 128'(out_vld),        128'(0));
      chk("abort_rdy", 128'(in_rdy),         128'(0));
      chk("abort_q",   q,                    128'(0));
      chk("abort_rec", rec,                  128'(0));
      chk("abort_mp",  128'(mp),             128'(0));
      chk("abort_blk", 128'(out_blkcounter), 128'(0));
      tick();
      rstn = 1'b0;
      tick();
      chk("abort_no_emit", 128'(out_vld), 128'(0));
      chk("rdy_after_abort", 128'(in_rdy), 128'(1));

      // mean restored to 128 by reset (carried 72 would give mp 128)
      send(16'd5, rep(8'd128));
      chk_out("after_rst", rep(8'hFF), rep(8'd128), 8'd132, 16'd5);
      consume();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
